// File: rtl/noise_voice_scheduler.sv
// Per-voice 23-bit noise LFSR bank sharing one step datapath.
// A round-robin arbiter grants at most one pending step request per cycle.
module noise_voice_scheduler #(
    parameter int          NUM_VOICES  = 4,
    parameter int          VW          = 2,
    parameter int          OUTPUT_BITS = 12,
    parameter logic [22:0] SEED        = 23'b01101110010010000101011
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_VOICES-1:0]  shift_req,
    input  logic [NUM_VOICES-1:0]  voice_test,
    input  logic [VW-1:0]          rd_voice,
    output logic [OUTPUT_BITS-1:0] dout,
    output logic                   busy,
    output logic [NUM_VOICES-1:0]  overrun,
    input  logic                   overrun_clr
);

    function automatic logic [22:0] lfsr_step(input logic [22:0] s);
        lfsr_step = {s[21:0], s[22] ^ s[17]};
    endfunction

    function automatic logic [OUTPUT_BITS-1:0] noise_taps(input logic [22:0] s);
        noise_taps = '0;
        noise_taps[OUTPUT_BITS-1 -: 8] = {s[22], s[20], s[16], s[13], s[11], s[7], s[4], s[2]};
    endfunction

    logic [22:0]            r_state [NUM_VOICES];
    logic [NUM_VOICES-1:0]  r_pending;
    logic [NUM_VOICES-1:0]  r_overrun;
    logic [VW-1:0]          r_rr_ptr;
    logic [OUTPUT_BITS-1:0] r_dout;

    logic [NUM_VOICES-1:0]  w_eligible;
    logic [NUM_VOICES-1:0]  w_grant_oh;
    logic                   w_grant_vld;
    logic [VW-1:0]          w_rr_next;
    logic [NUM_VOICES-1:0]  w_overrun_set;

    // Voices in test mode are never eligible, even on the cycle test is raised.
    assign w_eligible = r_pending & ~voice_test;

    always_comb begin
        int idx;
        int nxt;
        idx         = 0;
        nxt         = 0;
        w_grant_vld = 1'b0;
        w_grant_oh  = '0;
        w_rr_next   = r_rr_ptr;
        for (int i = 0; i < NUM_VOICES; i++) begin
            idx = (int'(r_rr_ptr) + i) % NUM_VOICES;
            if (!w_grant_vld && w_eligible[idx]) begin
                w_grant_vld     = 1'b1;
                w_grant_oh[idx] = 1'b1;
                nxt             = (idx + 1) % NUM_VOICES;
                w_rr_next       = nxt[VW-1:0];
            end
        end
    end

    // A request that lands on an already-pending, ungranted voice is merged and lost.
    assign w_overrun_set = shift_req & r_pending & ~w_grant_oh & ~voice_test;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_overrun <= '0;
            r_rr_ptr  <= '0;
            r_dout    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_state[v] <= SEED;
            end
        end else begin
            r_pending <= ((r_pending & ~w_grant_oh) | shift_req) & ~voice_test;
            r_overrun <= (r_overrun & {NUM_VOICES{~overrun_clr}}) | w_overrun_set;
            if (w_grant_vld) begin
                r_rr_ptr <= w_rr_next;
            end
            if (int'(rd_voice) < NUM_VOICES) begin
                r_dout <= noise_taps(r_state[rd_voice]);
            end else begin
                r_dout <= '0;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_test[v]) begin
                    r_state[v] <= SEED;
                end else if (w_grant_oh[v]) begin
                    r_state[v] <= lfsr_step(r_state[v]);
                end
            end
        end
    end

    assign dout    = r_dout;
    assign busy    = |r_pending;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_noise_voice_scheduler.sv
// Directed and randomized bench for noise_voice_scheduler against a per-voice
// behavioural model of request merging, round-robin service and noise taps.
module tb_noise_voice_scheduler;

    localparam int          N    = 4;
    localparam logic [22:0] SEED = 23'b01101110010010000101011;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  shift_req;
    logic [N-1:0]  voice_test;
    logic [1:0]    rd_voice;
    logic [11:0]   dout;
    logic          busy;
    logic [N-1:0]  overrun;
    logic          overrun_clr;

    int checks = 0;
    int errors = 0;

    logic [22:0] m_state [N];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovr;
    logic [11:0]  m_dout;
    int           m_rr;

    noise_voice_scheduler #(
        .NUM_VOICES(N), .VW(2), .OUTPUT_BITS(12), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .shift_req(shift_req), .voice_test(voice_test),
        .rd_voice(rd_voice), .dout(dout), .busy(busy), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_taps(input logic [22:0] s);
        int tap_pos [8] = '{22, 20, 16, 13, 11, 7, 4, 2};
        logic [11:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[11 - k] = s[tap_pos[k]];
        return r;
    endfunction

    function automatic logic [22:0] ref_step(input logic [22:0] s);
        logic fb;
        fb = s[22] ^ s[17];
        return (s << 1) | {22'd0, fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One clock edge: advance the model from the inputs now applied, then compare.
    task automatic tick();
        int g;
        if (rst) begin
            for (int v = 0; v < N; v++) m_state[v] = SEED;
            m_pend = '0; m_ovr = '0; m_dout = '0; m_rr = 0;
        end else begin
            logic [22:0] n_state [N];
            logic [N-1:0] n_pend;
            logic [N-1:0] n_ovr;
            m_dout = ref_taps(m_state[rd_voice]);
            g = -1;
            for (int i = 0; i < N; i++) begin
                int v;
                v = (m_rr + i) % N;
                if (g < 0 && m_pend[v] && !voice_test[v]) g = v;
            end
            n_ovr = overrun_clr ? '0 : m_ovr;
            for (int v = 0; v < N; v++) begin
                n_state[v] = m_state[v];
                if (voice_test[v]) begin
                    n_state[v] = SEED;
                    n_pend[v]  = 1'b0;
                end else begin
                    if (shift_req[v] && m_pend[v] && v != g) n_ovr[v] = 1'b1;
                    if (v == g) begin
                        n_state[v] = ref_step(m_state[v]);
                        n_pend[v]  = shift_req[v];
                    end else begin
                        n_pend[v] = m_pend[v] | shift_req[v];
                    end
                end
            end
            for (int v = 0; v < N; v++) m_state[v] = n_state[v];
            m_pend = n_pend;
            m_ovr  = n_ovr;
            if (g >= 0) m_rr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        chk("dout", 32'(dout), 32'(m_dout));
        chk("busy", 32'(busy), 32'(|m_pend));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic do_reset();
        rst = 1'b1; shift_req = '0; voice_test = '0; overrun_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; shift_req = '0; voice_test = '0; rd_voice = '0; overrun_clr = 1'b0;
        do_reset();
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        tick();
        chk("seed_taps", 32'(dout), 32'h700);

        // single request on voice 0
        shift_req = 4'b0001; tick();
        chk("single_busy", 32'(busy), 32'h1);
        shift_req = '0; tick(); tick();
        chk("single_step", 32'(dout), 32'h8B0);
        rd_voice = 2'd1; tick();
        chk("other_voice", 32'(dout), 32'h700);

        // all four voices requested together
        do_reset();
        shift_req = 4'b1111; tick();
        shift_req = '0;
        for (int k = 0; k < 4; k++) begin
            chk("all_busy", 32'(busy), 32'h1);
            tick();
        end
        chk("all_idle", 32'(busy), 32'h0);
        for (int v = 0; v < N; v++) begin
            rd_voice = 2'(v); tick();
            chk("all_step", 32'(dout), 32'h8B0);
        end
        chk("all_no_overrun", 32'(overrun), 32'h0);

        // wrap order: rr_ptr=1, voices 0 and 2 pending -> 2 served first
        do_reset();
        shift_req = 4'b0001; tick();
        shift_req = '0; tick();
        shift_req = 4'b0101; tick();
        shift_req = '0; tick();
        rd_voice = 2'd2; tick();
        chk("wrap_order", 32'(dout), 32'h8B0);

        // overrun on voice 1 while voice 0 is served ahead of it
        do_reset();
        shift_req = 4'b0011; tick();
        shift_req = 4'b0010; tick();
        shift_req = '0; tick();
        chk("overrun_set", 32'(overrun), 32'h2);
        rd_voice = 2'd1; tick(); tick();
        chk("overrun_one_step", 32'(dout), 32'h8B0);
        overrun_clr = 1'b1; tick();
        overrun_clr = 1'b0;
        chk("overrun_clr", 32'(overrun), 32'h0);

        // test mode on voice 3 holds it at the seed
        voice_test = 4'b1000; rd_voice = 2'd3;
        for (int k = 0; k < 4; k++) begin
            shift_req = (k % 2 == 0) ? 4'b1000 : 4'b0000;
            tick();
        end
        shift_req = '0; tick();
        chk("test_hold", 32'(dout), 32'h700);
        chk("test_no_pending", 32'(busy), 32'h0);
        voice_test = '0; tick();

        // reset with steps pending
        shift_req = 4'b1111; tick();
        shift_req = '0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'h0);
        for (int v = 0; v < N; v++) begin
            rd_voice = 2'(v); tick();
            chk("rst_seed", 32'(dout), 32'h700);
        end

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            overrun_clr = ($urandom_range(0, 9) == 0);
            rd_voice    = 2'($urandom_range(0, 3));
            for (int v = 0; v < N; v++) begin
                shift_req[v]  = ($urandom_range(0, 3) == 0);
                voice_test[v] = ($urandom_range(0, 15) == 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
